pong_sprite_engine: RTL and testbench

Parametrised sprite draw/move engine for the Motion Pong VGA path. It owns one rectangular sprite (ball or paddle) of SPR_W × SPR_H pixels and moves it one pixel per frame, bouncing off the screen edges. Each frame it erases the sprite at its last drawn position, updates the position, and redraws it, streaming one pixel per clock to the VGA adapter's x/y/colour/plot inputs. It is a successor to the fixed 4×4, single-step square datapath, adding sizing parameters, velocity, bounce, erase and position load.

---
 rtl/pong_sprite_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_pong_sprite_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_sprite_engine.sv
// Single-sprite erase/move/redraw engine: once per frame it streams the erase pass, moves the
// sprite one pixel (bouncing off screen edges or jumping to a loaded position), then redraws it.
module pong_sprite_engine #(
  parameter int unsigned SPR_W       = 4,
  parameter int unsigned SPR_H       = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned FRAME_TICKS = 833333,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       ld_pos,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic [2:0] colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       hit_x,
  output logic       hit_y
);

  localparam int unsigned PXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned PYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned FCW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [PXW-1:0] PX_LAST   = PXW'(SPR_W - 1);
  localparam logic [PYW-1:0] PY_LAST   = PYW'(SPR_H - 1);
  localparam logic [FCW-1:0] FC_RELOAD = FCW'(FRAME_TICKS - 1);
  localparam logic [7:0]     MAX_X     = 8'(SCREEN_W - SPR_W);
  localparam logic [6:0]     MAX_Y     = 7'(SCREEN_H - SPR_H);

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StUpdate,
    StDraw,
    StWait
  } state_e;

  state_e         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           tick;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic           last_pix;

  logic [7:0] cur_x_q, cur_x_d, drawn_x_q, drawn_x_d, ld_x_q, ld_x_d;
  logic [6:0] cur_y_q, cur_y_d, drawn_y_q, drawn_y_d, ld_y_q, ld_y_d;
  logic       vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic       pend_q, pend_d;
  logic [2:0] draw_col_q, draw_col_d;
  logic       hit_x_d, hit_y_d;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] col_d;
  logic       plot_d, busy_d;

  // Frame counter keeps running during a pass, so a tick landing mid-pass is simply lost.
  always_comb begin
    tick   = enable && (fcnt_q == '0);
    fcnt_d = fcnt_q;
    if (tick) begin
      fcnt_d = FC_RELOAD;
    end else if (enable) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  assign last_pix = (px_q == PX_LAST) && (py_q == PY_LAST);

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    case (state_q)
      StIdle, StWait: begin
        if (tick) begin
          state_d = StErase;
          px_d    = '0;
          py_d    = '0;
        end
      end
      StErase, StDraw: begin
        if (last_pix) begin
          state_d = (state_q == StErase) ? StUpdate : StWait;
        end else if (px_q == PX_LAST) begin
          px_d = '0;
          py_d = py_q + 1'b1;
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      StUpdate: begin
        state_d = StDraw;
        px_d    = '0;
        py_d    = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    vx_neg_d   = vx_neg_q;
    vy_neg_d   = vy_neg_q;
    pend_d     = pend_q;
    ld_x_d     = ld_x_q;
    ld_y_d     = ld_y_q;
    drawn_x_d  = drawn_x_q;
    drawn_y_d  = drawn_y_q;
    draw_col_d = draw_col_q;
    hit_x_d    = 1'b0;
    hit_y_d    = 1'b0;

    if (state_q == StUpdate) begin
      if (pend_q) begin
        cur_x_d = (ld_x_q > MAX_X) ? MAX_X : ld_x_q;
        cur_y_d = (ld_y_q > MAX_Y) ? MAX_Y : ld_y_q;
        pend_d  = 1'b0;
      end else begin
        if (!vx_neg_q && (cur_x_q == MAX_X)) begin
          vx_neg_d = 1'b1;
          cur_x_d  = cur_x_q - 1'b1;
          hit_x_d  = 1'b1;
        end else if (vx_neg_q && (cur_x_q == '0)) begin
          vx_neg_d = 1'b0;
          cur_x_d  = 8'd1;
          hit_x_d  = 1'b1;
        end else begin
          cur_x_d = vx_neg_q ? cur_x_q - 1'b1 : cur_x_q + 1'b1;
        end

        if (!vy_neg_q && (cur_y_q == MAX_Y)) begin
          vy_neg_d = 1'b1;
          cur_y_d  = cur_y_q - 1'b1;
          hit_y_d  = 1'b1;
        end else if (vy_neg_q && (cur_y_q == '0)) begin
          vy_neg_d = 1'b0;
          cur_y_d  = 7'd1;
          hit_y_d  = 1'b1;
        end else begin
          cur_y_d = vy_neg_q ? cur_y_q - 1'b1 : cur_y_q + 1'b1;
        end
      end
      drawn_x_d  = cur_x_d;
      drawn_y_d  = cur_y_d;
      draw_col_d = colour;
    end

    // A load arriving on the UPDATE cycle itself is kept for the following frame.
    if (ld_pos) begin
      ld_x_d = pos_x;
      ld_y_d = pos_y;
      pend_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so each plot cycle lines up with its state.
  always_comb begin
    x_d    = '0;
    y_d    = '0;
    col_d  = '0;
    plot_d = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      StErase: begin
        plot_d = 1'b1;
        busy_d = 1'b1;
        x_d    = drawn_x_q + 8'(px_d);
        y_d    = drawn_y_q + 7'(py_d);
        col_d  = BG_COLOUR;
      end
      StUpdate: begin
        busy_d = 1'b1;
      end
      StDraw: begin
        plot_d = 1'b1;
        busy_d = 1'b1;
        x_d    = cur_x_d + 8'(px_d);
        y_d    = cur_y_d + 7'(py_d);
        col_d  = draw_col_d;
      end
      default: begin
        plot_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      fcnt_q     <= FC_RELOAD;
      px_q       <= '0;
      py_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      drawn_x_q  <= '0;
      drawn_y_q  <= '0;
      ld_x_q     <= '0;
      ld_y_q     <= '0;
      vx_neg_q   <= 1'b0;
      vy_neg_q   <= 1'b0;
      pend_q     <= 1'b0;
      draw_col_q <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      hit_x      <= 1'b0;
      hit_y      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      drawn_x_q  <= drawn_x_d;
      drawn_y_q  <= drawn_y_d;
      ld_x_q     <= ld_x_d;
      ld_y_q     <= ld_y_d;
      vx_neg_q   <= vx_neg_d;
      vy_neg_q   <= vy_neg_d;
      pend_q     <= pend_d;
      draw_col_q <= draw_col_d;
      x_out      <= x_d;
      y_out      <= y_d;
      colour_out <= col_d;
      plot       <= plot_d;
      busy       <= busy_d;
      hit_x      <= hit_x_d;
      hit_y      <= hit_y_d;
    end
  end

endmodule

// File: tb/tb_pong_sprite_engine.sv
// Bench for pong_sprite_engine: a 4x4 and an 8x2 instance checked frame by frame against a
// position/velocity reflection model, with directed edge cases and randomized loads/colours.
module tb_pong_sprite_engine;

  localparam int FT    = 64;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic       ld_pos = 1'b0;
  logic [7:0] pos_x = '0;
  logic [6:0] pos_y = '0;
  logic [2:0] colour = 3'd4;

  logic [7:0] x_a, x_b, x_m;
  logic [6:0] y_a, y_b, y_m;
  logic [2:0] c_a, c_b, c_m;
  logic       plot_a, plot_b, plot_m, busy_a, busy_b, busy_m;
  logic       hx_a, hx_b, hx_m, hy_a, hy_b, hy_m;

  bit sel = 1'b0;

  always #5 clock = ~clock;

  pong_sprite_engine #(.FRAME_TICKS(FT)) dut_a (
    .clock(clock), .resetn(resetn), .enable(en_a), .ld_pos(ld_pos), .pos_x(pos_x),
    .pos_y(pos_y), .colour(colour), .x_out(x_a), .y_out(y_a), .colour_out(c_a),
    .plot(plot_a), .busy(busy_a), .hit_x(hx_a), .hit_y(hy_a)
  );

  pong_sprite_engine #(.SPR_W(8), .SPR_H(2), .FRAME_TICKS(FT)) dut_b (
    .clock(clock), .resetn(resetn), .enable(en_b), .ld_pos(ld_pos), .pos_x(pos_x),
    .pos_y(pos_y), .colour(colour), .x_out(x_b), .y_out(y_b), .colour_out(c_b),
    .plot(plot_b), .busy(busy_b), .hit_x(hx_b), .hit_y(hy_b)
  );

  assign x_m    = sel ? x_b : x_a;
  assign y_m    = sel ? y_b : y_a;
  assign c_m    = sel ? c_b : c_a;
  assign plot_m = sel ? plot_b : plot_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign hx_m   = sel ? hx_b : hx_a;
  assign hy_m   = sel ? hy_b : hy_a;

  int n_assert = 0;
  int n_fail = 0;
  int en_edges = 0;
  int sw = 4, sh = 4;
  int mx, my, mvx, mvy, dx, dy, lx, ly;
  bit pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; counts edges on which the selected instance had enable high.
  task automatic step();
    logic e;
    e = sel ? en_b : en_a;
    @(negedge clock);
    if (e) en_edges++;
  endtask

  task automatic set_en(input logic v);
    if (sel) en_b = v;
    else en_a = v;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; dx = 0; dy = 0; mvx = 1; mvy = 1; lx = 0; ly = 0; pend = 1'b0;
    en_edges = 0;
  endtask

  task automatic model_update(output bit hx, output bit hy);
    hx = 1'b0;
    hy = 1'b0;
    if (pend) begin
      mx = (lx < SCR_W - sw) ? lx : SCR_W - sw;
      my = (ly < SCR_H - sh) ? ly : SCR_H - sh;
      pend = 1'b0;
    end else begin
      if (mx + mvx < 0 || mx + mvx > SCR_W - sw) begin mvx = -mvx; hx = 1'b1; end
      if (my + mvy < 0 || my + mvy > SCR_H - sh) begin mvy = -mvy; hy = 1'b1; end
      mx += mvx;
      my += mvy;
    end
  endtask

  task automatic load(input int nx, input int ny);
    ld_pos = 1'b1; pos_x = 8'(nx); pos_y = 7'(ny);
    lx = nx; ly = ny; pend = 1'b1;
    step();
    ld_pos = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bit stray = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (busy_m !== 1'b0 || plot_m !== 1'b0) stray = 1'b1;
      step();
    end
    chk("parked_quiet", stray, 0);
  endtask

  task automatic wait_frame();
    bit stray = 1'b0;
    int guard = 0;
    while (busy_m !== 1'b1 && guard < 4 * FT) begin
      if (plot_m !== 1'b0) stray = 1'b1;
      step();
      guard++;
    end
    chk("idle_quiet", stray, 0);
    chk("frame_start", busy_m, 1);
    chk("frame_gap", en_edges, FT);
    en_edges = 0;
  endtask

  task automatic do_frame(input int ld_at, input int nlx, input int nly, input int drop_at,
                          input bit rand_col);
    int n, eh;
    bit ehx, ehy;
    logic [2:0] ecol;
    n = sw * sh;
    wait_frame();
    for (int i = 0; i < n; i++) begin
      chk("erase_plot", plot_m, 1);
      chk("erase_busy", busy_m, 1);
      chk("erase_x", x_m, dx + i % sw);
      chk("erase_y", y_m, dy + i / sw);
      chk("erase_colour", c_m, 0);
      chk("erase_hit", {hx_m, hy_m}, 0);
      step();
    end
    chk("update_plot", plot_m, 0);
    chk("update_busy", busy_m, 1);
    chk("update_hit", {hx_m, hy_m}, 0);
    if (rand_col) colour = 3'($urandom);
    ecol = colour;
    model_update(ehx, ehy);
    eh = (int'(ehx) << 1) | int'(ehy);
    step();
    for (int i = 0; i < n; i++) begin
      chk("draw_plot", plot_m, 1);
      chk("draw_busy", busy_m, 1);
      chk("draw_x", x_m, mx + i % sw);
      chk("draw_y", y_m, my + i / sw);
      chk("draw_colour", c_m, ecol);
      chk("draw_hit", {hx_m, hy_m}, (i == 0) ? eh : 0);
      if (rand_col) colour = 3'($urandom);
      ld_pos = (i == ld_at);
      if (i == ld_at) begin
        pos_x = 8'(nlx); pos_y = 7'(nly); lx = nlx; ly = nly; pend = 1'b1;
      end
      if (i == drop_at) set_en(1'b0);
      step();
    end
    ld_pos = 1'b0;
    dx = mx;
    dy = my;
    chk("done_busy", busy_m, 0);
    chk("done_plot", plot_m, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"}, x_a, 0);
    chk({tag, "_y"}, y_a, 0);
    chk({tag, "_colour"}, c_a, 0);
    chk({tag, "_plot"}, plot_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_hit"}, {hx_a, hy_a}, 0);
    chk({tag, "_b_plot"}, plot_b, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset");

    // 4x4 instance: basic frame, then edge, corner and clamping cases
    en_a = 1'b1;
    resetn = 1'b1;
    model_reset();
    do_frame(-1, 0, 0, -1, 1'b0);

    load(156, 50);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    load(40, 116);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    load(156, 116);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(5, 200, 127, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    load(0, 1);
    do_frame(7, 3, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);

    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1)
        do_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 127)), -1, 1'b1);
      else
        do_frame(-1, 0, 0, -1, 1'b1);
    end

    // Asynchronous reset in the middle of an erase pass
    wait_frame();
    repeat (3) step();
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    do_frame(-1, 0, 0, -1, 1'b1);

    // 8x2 instance: enable dropped mid-draw must park with the frame counter frozen
    en_a = 1'b0;
    sel = 1'b1;
    sw = 8;
    sh = 2;
    model_reset();
    idle_cycles(20);
    en_b = 1'b1;
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, 5, 1'b1);
    idle_cycles(150);
    en_b = 1'b1;
    do_frame(-1, 0, 0, -1, 1'b1);
    load(150, 117);
    do_frame(-1, 0, 0, -1, 1'b1);
    do_frame(-1, 0, 0, -1, 1'b1);
    for (int f = 0; f < 4; f++) begin
      do_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 127)), -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
